// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the two-core bus coherence controller.
package cpu_types_pkg;
  localparam int CPUS = 2;
  typedef logic [2:0] bus_state_t;
  localparam bus_state_t IDLE = 3'd0, ARB = 3'd1, SNOOP = 3'd2, RD_MEM = 3'd3,
                         RD_C2C = 3'd4, WR_MEM = 3'd5, INV = 3'd6, IFETCH = 3'd7;
  typedef enum logic [1:0] {DREAD, DWRITE, DINV, IREAD} bus_kind_t;
endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: data > invalidate > ifetch, core ties go to the core that was not served last.
module bus_rr_arbiter
  import cpu_types_pkg::*;
(
  input  logic [1:0] dren,
  input  logic [1:0] dwen,
  input  logic [1:0] ccwrite,
  input  logic [1:0] iren,
  input  logic       last,
  output logic       valid,
  output logic       core,
  output bus_kind_t  kind
);
  logic [1:0] d, req;
  always_comb begin
    d = dren | dwen;
    req = |d ? d : |ccwrite ? ccwrite : iren;
    valid = |req;
    core = &req ? ~last : req[1];
    kind = |d ? (dwen[core] ? DWRITE : DREAD) : |ccwrite ? DINV : IREAD;
  end
endmodule

// File: rtl/coherence_ctrl.sv
// coherence_ctrl: arbitrates two icache/dcache pairs onto one RAM port, snooping the other dcache
// and serving cache-to-cache transfers when the snooped cache holds the word Modified.
module coherence_ctrl
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic [1:0]      iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]      iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]      dREN,
  input  logic [1:0]      dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]      ccwrite,
  output logic [1:0]      dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]      ccwait,
  output logic [1:0]      ccinv,
  output logic [1:0][31:0] snoopaddr,
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  logic            ramwait
);
  bus_state_t state, next;
  bus_kind_t kind, arb_kind;
  logic g, j, last, arb_valid, arb_core, mem, done, snoop;
  logic [31:0] addr, c2c;
  bus_rr_arbiter u_arb (
    .dren(dREN), .dwen(dWEN), .ccwrite(ccwrite), .iren(iREN), .last(last),
    .valid(arb_valid), .core(arb_core), .kind(arb_kind)
  );
  assign j = ~g;
  assign mem = state == RD_MEM || state == RD_C2C || state == WR_MEM || state == IFETCH;
  assign done = (mem && !ramwait) || state == INV;
  assign snoop = state == SNOOP || state == INV;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = |{dREN, dWEN, ccwrite, iREN} ? ARB : IDLE;
      ARB: next = !arb_valid ? IDLE : arb_kind == DWRITE ? WR_MEM : arb_kind == DREAD ? SNOOP :
                  arb_kind == DINV ? INV : IFETCH;
      SNOOP: next = ccwrite[j] ? RD_C2C : RD_MEM;
      default: next = done ? IDLE : state;
    endcase
  end
  // c2c doubles as the writeback data latch; a snoop hit overwrites it with the supplier's word
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      g <= 1'b0;
      kind <= DREAD;
      addr <= '0;
      c2c <= '0;
      last <= 1'b1;
    end else begin
      state <= next;
      if (state == ARB) begin
        g <= arb_core;
        kind <= arb_kind;
        addr <= arb_kind == IREAD ? iaddr[arb_core] : daddr[arb_core];
        c2c <= dstore[arb_core];
      end
      if (state == SNOOP && ccwrite[j]) c2c <= dstore[j];
      if (done && kind != IREAD) last <= g;
    end
  always_comb begin
    ccwait = '0;
    ccinv = '0;
    snoopaddr = '0;
    dwait = '1;
    iwait = '1;
    dload = '0;
    iload = '0;
    ccwait[j] = snoop;
    ccinv[j] = state == INV;
    snoopaddr[j] = snoop ? addr : '0;
    dwait[g] = !(done && kind != IREAD);
    iwait[g] = !(done && kind == IREAD);
    dload[g] = state == RD_MEM ? ramload : state == RD_C2C ? c2c : '0;
    iload[g] = state == IFETCH ? ramload : '0;
    ramREN = state == RD_MEM || state == IFETCH;
    ramWEN = state == WR_MEM || state == RD_C2C;
    ramaddr = mem ? addr : '0;
    ramstore = ramWEN ? c2c : '0;
  end
endmodule

// File: tb/tb_coherence_ctrl.sv
// tb_coherence_ctrl: vector table, directed corner sequences and a randomized transaction-level model.
module tb_coherence_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] iREN, dREN, dWEN, ccwrite, iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload, snoopaddr;
  logic ramREN, ramWEN, ramwait;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ccw_req, mod_v;
  logic [1:0][31:0] st_req, mod_a, mod_d;
  logic [31:0] ram [0:255];
  logic fill, pre_we;
  logic [31:0] pre_a, pre_d;
  int checks = 0, errors = 0;

  typedef struct {
    int cyc; logic core; logic isi; logic [31:0] load, ra, sa; logic ren, wen, inv;
  } comp_t;
  typedef struct {
    logic [1:0] dren, dwen, ccw, iren;
    logic [31:0] a0, a1, s0, s1;
    logic mod_on, mod_k; logic [31:0] mod_a, mod_d;
    int cyc; logic core, isi; logic [31:0] load, mem_a, mem_d;
  } vec_t;
  comp_t cq[$];
  int snp_cyc;
  logic [31:0] snp_a;

  always #5 CLK = ~CLK;

  coherence_ctrl dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .snoopaddr(snoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
  );

  assign ramload = ram[ramaddr[9:2]];
  always @(posedge CLK)
    if (fill) for (int w = 0; w < 256; w++) ram[w] <= {4{w[7:0]}};
    else if (pre_we) ram[pre_a[9:2]] <= pre_d;
    else if (ramWEN && !ramwait) ram[ramaddr[9:2]] <= ramstore;

  // each dcache answers read snoops from its own Modified word, otherwise drives its request
  for (genvar k = 0; k < 2; k++) begin : g_cache
    assign ccwrite[k] = (ccwait[k] && !ccinv[k]) ? (mod_v[k] && mod_a[k] == snoopaddr[k]) : ccw_req[k];
    assign dstore[k] = (ccwait[k] && !ccinv[k]) ? mod_d[k] : st_req[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Requests must be set at a negedge just before the call; cycle k is k posedges later.
  task automatic run(input int st, input int maxc);
    int sc;
    logic [1:0] clr;
    sc = 0; clr = '0;
    cq.delete(); snp_cyc = 0; snp_a = '0;
    for (int k = 1; k <= maxc && |{dREN, dWEN, ccw_req, iREN}; k++) begin
      @(negedge CLK);
      mod_v &= ~clr;
      clr = '0;
      ramwait = (ramREN || ramWEN) && sc < st;
      sc = (ramREN || ramWEN) ? sc + 1 : 0;
      #1;
      checks++;
      if ($countones({~dwait, ~iwait}) > 1) begin
        errors++;
        $display("FAIL one_wait: got dwait=%b iwait=%b expected at most one low", dwait, iwait);
      end
      for (int c = 0; c < 2; c++) begin
        clr[c] = ccwait[c] && mod_v[c] && mod_a[c] == snoopaddr[c];
        if (ccwait[c] && !ccinv[c]) begin snp_cyc = k; snp_a = snoopaddr[c]; end
        if (!dwait[c] || !iwait[c])
          cq.push_back('{cyc: k, core: 1'(c), isi: !iwait[c], load: !iwait[c] ? iload[c] : dload[c],
                         ra: ramaddr, sa: snoopaddr[1-c], ren: ramREN, wen: ramWEN, inv: ccinv[1-c]});
        if (!dwait[c]) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; ccw_req[c] = 1'b0; end
        if (!iwait[c]) iREN[c] = 1'b0;
      end
    end
    if (|{dREN, dWEN, ccw_req, iREN}) begin
      checks++; errors++;
      $display("FAIL timeout: got pending requests after %0d cycles expected completion", maxc);
      dREN = '0; dWEN = '0; ccw_req = '0; iREN = '0;
    end
    ramwait = 1'b0;
  endtask

  function automatic int cls(input int o);
    return (o == 1 || o == 2) ? 3 : o == 3 ? 2 : o == 4 ? 1 : 0;
  endfunction

  vec_t vt [8];
  logic [31:0] ref_mem [0:7];

  initial begin
    int op [2], n, st, cyc, lat, w;
    logic [31:0] a [2], s [2], ma [2], md [2], exp_ld;
    logic mv [2], m_last, g, jj, hit;
    vt[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h100, '0, '0, '0, 1'b0, 1'b0, '0, '0,
              3, 1'b0, 1'b0, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF};
    vt[1] = '{2'b10, 2'b00, 2'b00, 2'b00, '0, 32'h200, '0, '0, 1'b1, 1'b0, 32'h200, 32'h12345678,
              3, 1'b1, 1'b0, 32'h12345678, 32'h200, 32'h12345678};
    vt[2] = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h40, '0, 32'hAAAA5555, '0, 1'b0, 1'b0, '0, '0,
              2, 1'b0, 1'b0, '0, 32'h40, 32'hAAAA5555};
    vt[3] = '{2'b00, 2'b00, 2'b01, 2'b00, 32'h300, '0, '0, '0, 1'b0, 1'b0, '0, '0,
              2, 1'b0, 1'b0, '0, 32'h300, 32'hC0C0C0C0};
    vt[4] = '{2'b00, 2'b00, 2'b00, 2'b10, '0, 32'h80, '0, '0, 1'b0, 1'b0, '0, '0,
              2, 1'b1, 1'b1, 32'h20202020, 32'h80, 32'h20202020};
    vt[5] = '{2'b00, 2'b10, 2'b00, 2'b00, '0, 32'h3FC, '0, 32'h0BADF00D, 1'b1, 1'b0, 32'h3FC, 32'h55555555,
              2, 1'b1, 1'b0, '0, 32'h3FC, 32'h0BADF00D};
    vt[6] = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h104, '0, '0, '0, 1'b1, 1'b1, 32'h108, 32'hFFFFFFFF,
              3, 1'b0, 1'b0, 32'h41414141, 32'h104, 32'h41414141};
    vt[7] = '{2'b10, 2'b00, 2'b00, 2'b00, '0, 32'h3FC, '0, '0, 1'b0, 1'b0, '0, '0,
              3, 1'b1, 1'b0, 32'h0BADF00D, 32'h3FC, 32'h0BADF00D};
    iREN = '0; dREN = '0; dWEN = '0; ccw_req = '0; iaddr = '0; daddr = '0; st_req = '0;
    mod_v = '0; mod_a = '0; mod_d = '0; ramwait = 1'b0; fill = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(negedge CLK);
    fill = 1'b0;
    #1;
    check("rst_waits", {dwait, iwait, ccwait, ccinv}, 32'hF0);
    check("rst_ram", {ramREN, ramWEN, ramaddr | ramstore}, '0);
    check("rst_loads", dload | iload, '0);
    check("rst_snoopaddr", snoopaddr, '0);
    nRST = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check("idle", {dwait, iwait, ccwait, ramREN, ramWEN}, 32'hF0);
    end
    poke(32'h100, 32'hDEADBEEF);

    for (int v = 0; v < 8; v++) begin
      @(negedge CLK);
      mod_v = '0;
      mod_v[vt[v].mod_k] = vt[v].mod_on;
      mod_a[vt[v].mod_k] = vt[v].mod_a;
      mod_d[vt[v].mod_k] = vt[v].mod_d;
      dREN = vt[v].dren; dWEN = vt[v].dwen; ccw_req = vt[v].ccw; iREN = vt[v].iren;
      daddr = {vt[v].a1, vt[v].a0}; iaddr = {vt[v].a1, vt[v].a0}; st_req = {vt[v].s1, vt[v].s0};
      run(0, 20);
      repeat (2) @(negedge CLK);
      check($sformatf("v%0d_count", v), cq.size(), 1);
      if (cq.size() == 0) cq.push_back('{default: '0});
      check($sformatf("v%0d_cycle", v), cq[0].cyc, vt[v].cyc);
      check($sformatf("v%0d_core", v), {cq[0].core, cq[0].isi}, {vt[v].core, vt[v].isi});
      check($sformatf("v%0d_load", v), cq[0].load, vt[v].load);
      check($sformatf("v%0d_mem", v), ram[vt[v].mem_a[9:2]], vt[v].mem_d);
      if (|vt[v].dren) begin
        check($sformatf("v%0d_snoop_cyc", v), snp_cyc, 2);
        check($sformatf("v%0d_snoop_addr", v), snp_a, vt[v].core ? vt[v].a1 : vt[v].a0);
      end
      if (|vt[v].ccw)
        check($sformatf("v%0d_inv", v), {cq[0].inv, cq[0].ren, cq[0].wen, cq[0].sa}, {3'b100, vt[v].a0});
    end

    // simultaneous writebacks from reset: core 0 first, one completion per core
    do_reset();
    dWEN = 2'b11; daddr = {32'h14, 32'h10}; st_req = {32'h22222222, 32'h11111111};
    run(0, 30);
    repeat (2) @(negedge CLK);
    check("ww_count", cq.size(), 2);
    while (cq.size() < 2) cq.push_back('{default: '0});
    check("ww_first", {cq[0].core, cq[0].ra}, {1'b0, 32'h10});
    check("ww_second", {cq[1].core, cq[1].ra}, {1'b1, 32'h14});
    check("ww_cycles", {cq[0].cyc[15:0], cq[1].cyc[15:0]}, {16'd2, 16'd5});
    check("ww_mem", {ram[4], ram[5]} == {32'h11111111, 32'h22222222}, 1);

    // data beats ifetch; every RAM access stalls 3 cycles
    poke(32'h84, 32'h21212121);
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h84; dREN = 2'b10; daddr[1] = 32'h100;
    run(3, 40);
    check("di_count", cq.size(), 2);
    while (cq.size() < 2) cq.push_back('{default: '0});
    check("di_data", {cq[0].core, cq[0].isi, cq[0].cyc[7:0]}, {1'b1, 1'b0, 8'd6});
    check("di_data_load", cq[0].load, 32'hDEADBEEF);
    check("di_ifetch", {cq[1].core, cq[1].isi, cq[1].cyc[7:0]}, {1'b0, 1'b1, 8'd12});
    check("di_ifetch_load", cq[1].load, 32'h21212121);

    // asynchronous reset while an ifetch is stalled
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h88; ramwait = 1'b1;
    repeat (3) @(negedge CLK);
    #1 check("mid_ifetch", {ramREN, ramaddr}, {1'b1, 32'h88});
    #2 nRST = 1'b0;
    #1;
    check("arst_waits", {dwait, iwait, ccwait, ccinv}, 32'hF0);
    check("arst_ram", {ramREN, ramWEN, ramaddr | ramstore}, '0);
    check("arst_loads", dload | iload, '0);
    iREN = '0; ramwait = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // randomized pairs against the transaction-level model
    do_reset();
    m_last = 1'b1;
    for (int k = 0; k < 8; k++) ref_mem[k] = ram[8'h80 + k];
    for (int t = 0; t < 150; t++) begin
      st = $urandom_range(0, 2);
      for (int c = 0; c < 2; c++) begin
        op[c] = $urandom_range(0, 4);
        a[c] = 32'h200 + 4 * $urandom_range(0, 7);
        s[c] = $urandom;
        mv[c] = $urandom_range(0, 2) == 0;
        ma[c] = 32'h200 + 4 * $urandom_range(0, 7);
        md[c] = $urandom;
      end
      if (op[0] == 0 && op[1] == 0) op[0] = 1;
      @(negedge CLK);
      for (int c = 0; c < 2; c++) begin
        mod_v[c] = mv[c]; mod_a[c] = ma[c]; mod_d[c] = md[c];
        dREN[c] = op[c] == 1; dWEN[c] = op[c] == 2; ccw_req[c] = op[c] == 3; iREN[c] = op[c] == 4;
        daddr[c] = a[c]; iaddr[c] = a[c]; st_req[c] = s[c];
      end
      run(st, 60);
      n = int'(op[0] != 0) + int'(op[1] != 0);
      check("rnd_count", cq.size(), n);
      while (cq.size() < n) cq.push_back('{default: '0});
      g = cls(op[0]) > cls(op[1]) ? 1'b0 : cls(op[1]) > cls(op[0]) ? 1'b1 : ~m_last;
      cyc = 0;
      for (int e = 0; e < n; e++) begin
        jj = ~g;
        w = int'((a[g] - 32'h200) >> 2);
        lat = op[g] == 1 ? 3 + st : op[g] == 3 ? 2 : 2 + st;
        cyc = e == 0 ? lat : cyc + 1 + lat;
        exp_ld = '0;
        hit = mv[jj] && ma[jj] == a[g];
        if (op[g] == 1) begin
          exp_ld = hit ? md[jj] : ref_mem[w];
          ref_mem[w] = exp_ld;
          if (hit) mv[jj] = 1'b0;
        end else if (op[g] == 2) ref_mem[w] = s[g];
        else if (op[g] == 3) begin
          if (hit) mv[jj] = 1'b0;
        end else exp_ld = ref_mem[w];
        if (op[g] != 4) m_last = g;
        check($sformatf("rnd%0d_%0d_who", t, e), {cq[e].core, cq[e].isi}, {g, op[g] == 4});
        check($sformatf("rnd%0d_%0d_cycle", t, e), cq[e].cyc, cyc);
        check($sformatf("rnd%0d_%0d_load", t, e), cq[e].load, exp_ld);
        g = ~g;
      end
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 8; k++) check($sformatf("rnd_mem%0d", k), ram[8'h80 + k], ref_mem[k]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary expected completion within 50000 cycles");
    $fatal(1);
  end
endmodule

// File: doc/coherence_ctrl.md
# coherence_ctrl

Bus-side coherence and memory controller serving two cores. It arbitrates instruction fetches, data reads, and data writebacks from two icache/dcache pairs onto a single RAM port. It issues snoops (ccwait/ccinv/snoopaddr) to the non-requesting dcache and services cache-to-cache transfers when the snooped cache holds the word Modified. It sits between the per-core caches and the RAM model, and acts as the responder for every dREN/dWEN/ccwrite the dcaches initiate.

## Interface
- CPUS, 2, number of cores; only 2 is supported. Core j is always the "other" core, 1-i.
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  [1:0]  per-core instruction read request
- iaddr  in  [1:0][31:0]  instruction address
- iwait  out  [1:0]  1 = fetch not complete
- iload  out  [1:0][31:0]  fetched word, valid when iwait[i]=0
- dREN, dWEN  in  [1:0]  per-core data read / writeback request
- daddr  in  [1:0][31:0]  data address, word aligned
- dstore  in  [1:0][31:0]  writeback word; also the snoop-supplied word
- ccwrite  in  [1:0]  request-time: invalidate request (write hit); snoop-time: "I hold it Modified, data on dstore"
- dwait  out  [1:0]  1 = data access not complete
- dload  out  [1:0][31:0]  read word, valid when dwait[i]=0
- ccwait  out  [1:0]  cache i is being snooped
- ccinv  out  [1:0]  snoop is an invalidation
- snoopaddr  out  [1:0][31:0]  snooped address
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr, ramstore  out  32  RAM address / write data
- ramload  in  32  RAM read data
- ramwait  in  1  1 = RAM access not complete this cycle

## Operation
- States: IDLE, ARB, SNOOP, RD_MEM, RD_C2C, WR_MEM, INV, IFETCH.
- IDLE: if any request is pending, go to ARB.
- ARB chooses one request, in priority order:
  - data (dWEN or dREN) over ccwrite-only invalidation;
  - invalidation over iREN;
  - ties between cores are broken by round-robin bit `last`.
- `last` flips to the served core on every completed data/invalidate transaction.
- The grant (core g, kind, address) is registered in ARB.
- dWEN → WR_MEM: drive ramWEN, ramaddr=daddr[g], ramstore=dstore[g]. No snoop, since the writeback source is the only valid holder.
- dREN → SNOOP (one cycle): ccwait[j]=1, ccinv[j]=0, snoopaddr[j]=daddr[g]. Sample ccwrite[j]:
  - 1 → RD_C2C, and latch dstore[j] into the c2c register in this cycle.
  - 0 → RD_MEM.
- RD_MEM: ramREN, ramaddr=daddr[g]; dload[g]=ramload.
- RD_C2C: ramWEN with the latched word at daddr[g] (memory update; the supplier drops to S); dload[g]=latched word.
- ccwrite[g] alone → INV (one cycle): ccwait[j]=1, ccinv[j]=1, snoopaddr[j]=daddr[g]; dwait[g] pulses 0. Then go to IDLE.
- IFETCH: ramREN, ramaddr=iaddr[g]; iload[g]=ramload.
- Memory states complete in the cycle ramwait=0: dwait[g]/iwait[g]=0 in that cycle, then go to IDLE.
- Only the granted core's wait line ever drops. All other waits stay 1.
- Each word is a separate transaction; a 2-word block fill is two arbitrations.

## Timing
- Reset values (async):
  - state=IDLE, last=1 (so core 0 wins the first tie), c2c register=0;
  - dwait=2'b11, iwait=2'b11, ccwait=0, ccinv=0, snoopaddr=0;
  - ramREN=ramWEN=0, ramaddr=ramstore=0, dload=iload=0.
- All outputs are combinational from registered state/grant; no input-to-output path except ramload→dload/iload and ramwait→waits.
- Read latency with zero-wait RAM: request seen cycle 0 (IDLE), ARB cycle 1, SNOOP cycle 2, dwait low cycle 3. A C2C read is also complete in cycle 3 with zero-wait RAM.
- Writeback and ifetch: dwait/iwait low in cycle 2 with zero-wait RAM. Invalidate: dwait low in cycle 2.
- Each ramwait=1 cycle adds one cycle of latency.
- Requesters must hold the request and address until their wait drops. A request withdrawn mid-transaction is a protocol error; the controller still completes the RAM access.
- A request raised while the bus is busy waits; there is no preemption.
- Simultaneous dREN on both cores: the winner is the core ≠ last. The loser is snooped only by the winner's transaction and is served next.
- Reset mid-transaction: return to IDLE at once; strobes drop asynchronously. A partial RAM write is not retried.

## Structure
- cpu_types_pkg gains `bus_state_t` (the 8 states) and a `bus_kind_t` grant-kind enum (DREAD, DWRITE, DINV, IREAD).
- Natural sub-module: `bus_rr_arbiter`. It implements the priority plus round-robin pick, with inputs the request vectors and `last`, and outputs grant core and kind. It is combinational; `last` stays in the parent.

## Test plan
- Reset then idle: all waits=1, ccwait=0, ramREN=ramWEN=0; no state change for 10 cycles.
- Core0 dREN 0x100, RAM holds 0xDEADBEEF, ccwrite[1]=0:
  - ccwait[1]=1 and snoopaddr[1]=0x100 in cycle 2;
  - dload[0]=0xDEADBEEF with dwait[0]=0 in cycle 3.
- Core1 dREN 0x200 while core0 answers ccwrite[0]=1, dstore[0]=0x12345678:
  - dload[1]=0x12345678;
  - RAM[0x200]=0x12345678 afterwards.
- Both cores dWEN in the same cycle from reset: core0 served first (ramaddr=daddr[0]), then core1; each dwait drops exactly one cycle.
- Core0 ccwrite only, addr 0x300: one cycle with ccwait[1]=ccinv[1]=1 and snoopaddr[1]=0x300; dwait[0] drops that cycle; no RAM strobe.
- iREN[0] and dREN[1] together, ramwait=1 for 3 cycles: data served first with dwait[1] low in cycle 6, then the ifetch completes; nRST pulsed mid-ifetch returns all outputs to reset values.
